// File: rtl/key_spi_tx_pkg.sv
// rtl/key_spi_tx_pkg.sv - shared types and constants for the keypad SPI transmitter
package key_spi_tx_pkg;

  localparam int FRAME_W     = 8;
  localparam int KEY_W       = 7;
  localparam int SHIFT_EDGES = 2 * FRAME_W;
  localparam bit SPI_CPOL    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - first-word-fall-through FIFO buffering key codes
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/key_spi_tx.sv
// rtl/key_spi_tx.sv - buffers keypad codes and sends each as an 8-bit SPI mode-0 frame
module key_spi_tx
  import key_spi_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_ready,
  input  logic [KEY_W-1:0] key_code,
  output logic             sclk,
  output logic             mosi,
  output logic             cs_n,
  output logic             busy,
  output logic             overflow
);

  localparam int               TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(CLK_DIV - 1);
  localparam int               EW     = $clog2(SHIFT_EDGES);
  localparam logic [EW-1:0]    E_LAST = EW'(SHIFT_EDGES - 1);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [EW-1:0]      edge_q, edge_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               sclk_q, sclk_d;
  logic               loaded_q, loaded_d;
  logic               dr_q;
  logic               overflow_q;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_dout;
  logic               t_done;
  logic               frame_active;

  assign push   = data_ready & ~dr_q;
  assign t_done = (timer_q == T_LAST);

  key_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({{(FRAME_W - KEY_W){1'b0}}, key_code}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      edge_q     <= '0;
      shreg_q    <= '0;
      sclk_q     <= SPI_CPOL;
      loaded_q   <= 1'b0;
      dr_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      edge_q   <= edge_d;
      shreg_q  <= shreg_d;
      sclk_q   <= sclk_d;
      loaded_q <= loaded_d;
      dr_q     <= data_ready;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // loaded_q marks the one cycle between popping a code and dropping cs_n;
  // the end of GAP pops directly so the next frame starts one cycle later.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    edge_d   = edge_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    loaded_d = loaded_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (loaded_q) begin
          state_d  = ST_SETUP;
          loaded_d = 1'b0;
          timer_d  = '0;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          shreg_d  = fifo_dout;
          loaded_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (t_done) begin
          state_d = ST_SHIFT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (t_done) begin
          timer_d = '0;
          sclk_d  = ~sclk_q;
          edge_d  = edge_q + 1'b1;
          if (sclk_q) begin
            if (edge_q == E_LAST) state_d = ST_HOLD;
            else shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (t_done) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (t_done) begin
          state_d = ST_IDLE;
          timer_d = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            shreg_d  = fifo_dout;
            loaded_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign cs_n         = ~frame_active;
  assign mosi         = frame_active & shreg_q[FRAME_W-1];
  assign sclk         = sclk_q;
  assign busy         = (state_q != ST_IDLE) | loaded_q | ~fifo_empty;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_key_spi_tx.sv
// tb/tb_key_spi_tx.sv - randomized self-checking bench for key_spi_tx
module tb_key_spi_tx;

  localparam int DIV_A   = 4;
  localparam int DEPTH_A = 4;
  localparam int DIV_B   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       dr_a, dr_b;
  logic [6:0] key_a, key_b;
  logic       sclk_a, mosi_a, cs_n_a, busy_a, ovf_a;
  logic       sclk_b, mosi_b, cs_n_b, busy_b, ovf_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_spi_tx #(.FIFO_DEPTH(DEPTH_A), .CLK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .data_ready(dr_a), .key_code(key_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a), .overflow(ovf_a));

  key_spi_tx #(.FIFO_DEPTH(DEPTH_A), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .data_ready(dr_b), .key_code(key_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b), .overflow(ovf_b));

  // Reference model: a code queue that loses its head when a frame may start.
  // A frame may start one cycle after a push into an idle transmitter, and
  // successive frame starts are 19*CLK_DIV+1 cycles apart.
  int unsigned cyc = 0;
  int unsigned pop_ok = 0;
  int unsigned last_push_cyc = 0;
  logic [7:0]  mq[$];
  logic [7:0]  exp_a[$];
  bit          prev_dr_m = 1'b0;
  bit          ovf_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      pop_ok    = 0;
      prev_dr_m = 1'b0;
      ovf_m     = 1'b0;
    end else begin
      bit rise;
      cyc++;
      rise      = dr_a && !prev_dr_m;
      prev_dr_m = dr_a;
      if (mq.size() > 0 && cyc >= pop_ok) begin
        exp_a.push_back(mq.pop_front());
        pop_ok = cyc + 19 * DIV_A + 1;
      end
      if (rise) begin
        last_push_cyc = cyc;
        if (mq.size() < DEPTH_A) mq.push_back({1'b0, key_a});
        else ovf_m = 1'b1;
      end
    end
  end

  // SPI slave monitors, sampled on the falling clk edge.
  logic [7:0]  rx_a[$], rx_b[$];
  logic [7:0]  sh_a, sh_b;
  int          bits_a = 0, bits_b = 0, bit_err_a = 0, bit_err_b = 0;
  int          stab_err_a = 0, stab_err_b = 0, frames_b = 0;
  int unsigned fall_cyc_a = 0, low_len_a = 0, fall_cyc_b = 0, low_len_b = 0;
  int unsigned last_rise_b = 0, per_min_b = 1000, per_max_b = 0;
  bit          csp_a = 1'b1, sckp_a = 1'b0, mop_a = 1'b0;
  bit          csp_b = 1'b1, sckp_b = 1'b0, mop_b = 1'b0;

  always @(negedge clk) begin
    if (!cs_n_a && csp_a) begin bits_a = 0; sh_a = 8'h00; fall_cyc_a = cyc; end
    if (!cs_n_a && sclk_a && !sckp_a) begin
      if (mosi_a !== mop_a) stab_err_a++;
      sh_a = {sh_a[6:0], mosi_a};
      bits_a++;
    end
    if (cs_n_a && !csp_a) begin
      rx_a.push_back(sh_a);
      if (bits_a != 8) bit_err_a++;
      low_len_a = cyc - fall_cyc_a;
    end
    csp_a = cs_n_a; sckp_a = sclk_a; mop_a = mosi_a;
  end

  always @(negedge clk) begin
    if (!cs_n_b && csp_b) begin bits_b = 0; sh_b = 8'h00; fall_cyc_b = cyc; frames_b++; end
    if (!cs_n_b && sclk_b && !sckp_b) begin
      if (mosi_b !== mop_b) stab_err_b++;
      if (bits_b > 0) begin
        if (cyc - last_rise_b < per_min_b) per_min_b = cyc - last_rise_b;
        if (cyc - last_rise_b > per_max_b) per_max_b = cyc - last_rise_b;
      end
      last_rise_b = cyc;
      sh_b = {sh_b[6:0], mosi_b};
      bits_b++;
    end
    if (cs_n_b && !csp_b) begin
      rx_b.push_back(sh_b);
      if (bits_b != 8) bit_err_b++;
      low_len_b = cyc - fall_cyc_b;
    end
    csp_b = cs_n_b; sckp_b = sclk_b; mop_b = mosi_b;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    rx_a.delete(); exp_a.delete();
    bits_a = 0; bit_err_a = 0; stab_err_a = 0;
  endtask

  task automatic send_a(input logic [6:0] code, input int hi, input int lo);
    dr_a = 1'b1; key_a = code;
    repeat (hi) step();
    dr_a = 1'b0; key_a = 7'($urandom());
    repeat (lo) step();
  endtask

  task automatic wait_drain_a(input string name, input int budget);
    int n = 0;
    while (!(mq.size() == 0 && cyc >= pop_ok) && n < budget) begin step(); n++; end
    if (n >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: still pending after %0d cycles, required drained", name, budget);
    end
    step();
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (sclk_a !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk: got %b required 0", sclk_a); end
    n_tests++; if (mosi_a !== 1'b0)   begin n_fail++; $display("FAIL reset_mosi: got %b required 0", mosi_a); end
    n_tests++; if (cs_n_a !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n: got %b required 1", cs_n_a); end
    n_tests++; if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    n_tests++; if (ovf_a !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b required 0", ovf_a); end
    n_tests++; if (cs_n_b !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n_b: got %b required 1", cs_n_b); end
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_key();
    int lat;
    clear_sb();
    send_a(7'h5A, 3, 1);
    wait_drain_a("single", 300);
    n_tests++; if (rx_a.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d frames required 1", rx_a.size()); end
    if (rx_a.size() > 0) begin
      n_tests++; if (rx_a[0] !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h required 5a", rx_a[0]); end
    end
    lat = int'(fall_cyc_a) - int'(last_push_cyc);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL single_latency: got %0d required 2", lat); end
    n_tests++; if (low_len_a != 18 * DIV_A) begin n_fail++; $display("FAIL single_cs_low: got %0d required %0d", low_len_a, 18 * DIV_A); end
    n_tests++; if (bit_err_a != 0 || stab_err_a != 0) begin n_fail++; $display("FAIL single_bits: got %0d/%0d errors required 0", bit_err_a, stab_err_a); end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b required 0", ovf_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b required 0", busy_a); end
  endtask

  task automatic test_burst();
    logic [7:0] want[$];
    clear_sb();
    for (int i = 1; i <= 5; i++) begin want.push_back(8'(i)); send_a(7'(i), 1, 1); end
    wait_drain_a("burst", 800);
    n_tests++; if (rx_a.size() != want.size()) begin n_fail++; $display("FAIL burst_count: got %0d required %0d", rx_a.size(), want.size()); end
    for (int i = 0; i < want.size() && i < rx_a.size(); i++) begin
      n_tests++; if (rx_a[i] !== want[i]) begin n_fail++; $display("FAIL burst_data[%0d]: got %h required %h", i, rx_a[i], want[i]); end
    end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL burst_overflow: got %b required 0", ovf_a); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] want[$];
    int n = 0;
    clear_sb();
    for (int i = 1; i <= 5; i++) begin want.push_back(8'(8'h20 + i)); send_a(7'(8'h20 + i), 1, 1); end
    while (cyc != pop_ok - 1 && n < 200) begin step(); n++; end
    n_tests++; if (n >= 200) begin n_fail++; $display("FAIL ppf_align: pop slot not reached, got %0d cycles", n); end
    want.push_back(8'h26);
    send_a(7'h26, 1, 1);
    wait_drain_a("ppf", 800);
    n_tests++; if (rx_a.size() != want.size()) begin n_fail++; $display("FAIL ppf_count: got %0d required %0d", rx_a.size(), want.size()); end
    for (int i = 0; i < want.size() && i < rx_a.size(); i++) begin
      n_tests++; if (rx_a[i] !== want[i]) begin n_fail++; $display("FAIL ppf_data[%0d]: got %h required %h", i, rx_a[i], want[i]); end
    end
    n_tests++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ppf_overflow: got %b required 0", ovf_a); end
  endtask

  task automatic test_random();
    clear_sb();
    for (int i = 0; i < 16; i++) send_a(7'($urandom()), $urandom_range(1, 4), $urandom_range(1, 60));
    wait_drain_a("random", 4000);
    n_tests++; if (rx_a.size() != exp_a.size()) begin n_fail++; $display("FAIL random_count: got %0d required %0d", rx_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < rx_a.size(); i++) begin
      n_tests++; if (rx_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL random_data[%0d]: got %h required %h", i, rx_a[i], exp_a[i]); end
    end
    n_tests++; if (ovf_a !== ovf_m) begin n_fail++; $display("FAIL random_overflow: got %b required %b", ovf_a, ovf_m); end
    n_tests++; if (bit_err_a != 0 || stab_err_a != 0) begin n_fail++; $display("FAIL random_bits: got %0d/%0d errors required 0", bit_err_a, stab_err_a); end
  endtask

  task automatic test_overflow();
    logic [7:0] want[$];
    clear_sb();
    for (int i = 1; i <= 6; i++) begin
      if (i < 6) want.push_back(8'(8'h10 + i));
      send_a(7'(8'h10 + i), 1, 1);
    end
    wait_drain_a("overflow", 800);
    n_tests++; if (rx_a.size() != want.size()) begin n_fail++; $display("FAIL ovf_count: got %0d required %0d", rx_a.size(), want.size()); end
    for (int i = 0; i < want.size() && i < rx_a.size(); i++) begin
      n_tests++; if (rx_a[i] !== want[i]) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h required %h", i, rx_a[i], want[i]); end
    end
    n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", ovf_a); end
    repeat (40) step();
    n_tests++; if (ovf_a !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", ovf_a); end
  endtask

  task automatic test_mid_frame_reset();
    int n = 0;
    clear_sb();
    send_a(7'h44, 1, 1);
    send_a(7'h45, 1, 1);
    while (!(bits_a == 3 && !cs_n_a) && n < 300) begin step(); n++; end
    n_tests++; if (n >= 300) begin n_fail++; $display("FAIL rst_mid_reach: 4th bit not reached after %0d cycles", n); end
    rst = 1'b1;
    #1;
    n_tests++; if (cs_n_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cs_n: got %b required 1", cs_n_a); end
    n_tests++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sclk: got %b required 0", sclk_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", busy_a); end
    n_tests++; if (ovf_a !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_overflow: got %b required 0", ovf_a); end
    repeat (2) step();
    rst = 1'b0;
    clear_sb();
    repeat (3) step();
    n_tests++; if (busy_a !== 1'b0 || cs_n_a !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got busy=%b cs_n=%b required 0/1", busy_a, cs_n_a); end
    send_a(7'h33, 2, 1);
    wait_drain_a("rst_mid", 300);
    n_tests++; if (rx_a.size() != 1) begin n_fail++; $display("FAIL rst_mid_count: got %0d required 1", rx_a.size()); end
    if (rx_a.size() > 0) begin
      n_tests++; if (rx_a[0] !== 8'h33) begin n_fail++; $display("FAIL rst_mid_data: got %h required 33", rx_a[0]); end
    end
    n_tests++; if (bit_err_a != 0) begin n_fail++; $display("FAIL rst_mid_bits: got %0d errors required 0", bit_err_a); end
  endtask

  task automatic test_clk_div1();
    int n = 0;
    frames_b = 0; rx_b.delete(); bit_err_b = 0; stab_err_b = 0;
    per_min_b = 1000; per_max_b = 0;
    dr_b = 1'b1; key_b = 7'h7F;
    step();
    dr_b = 1'b0;
    while (!(frames_b == 1 && cs_n_b) && n < 100) begin step(); n++; end
    n_tests++; if (n >= 100) begin n_fail++; $display("FAIL div1_timeout: no frame after %0d cycles", n); end
    repeat (3) step();
    n_tests++; if (rx_b.size() != 1) begin n_fail++; $display("FAIL div1_count: got %0d required 1", rx_b.size()); end
    if (rx_b.size() > 0) begin
      n_tests++; if (rx_b[0] !== 8'h7F) begin n_fail++; $display("FAIL div1_data: got %h required 7f", rx_b[0]); end
    end
    n_tests++; if (per_min_b != 2 || per_max_b != 2) begin n_fail++; $display("FAIL div1_period: got %0d..%0d required 2", per_min_b, per_max_b); end
    n_tests++; if (stab_err_b != 0 || bit_err_b != 0) begin n_fail++; $display("FAIL div1_mosi: got %0d/%0d errors required 0", stab_err_b, bit_err_b); end
    n_tests++; if (low_len_b != 18 * DIV_B) begin n_fail++; $display("FAIL div1_cs_low: got %0d required %0d", low_len_b, 18 * DIV_B); end
    n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL div1_busy: got %b required 0", busy_b); end
  endtask

  initial begin
    rst = 1'b1; dr_a = 1'b0; dr_b = 1'b0; key_a = 7'h00; key_b = 7'h00;
    test_reset();
    test_single_key();
    test_burst();
    test_push_pop_full();
    test_random();
    test_overflow();
    test_mid_frame_reset();
    test_clk_div1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
